// File: rtl/cache_pkg.sv
// Shared definitions for the parametrised data cache: controller states and
// the tag-width derivation used by the top level and the line store.
package cache_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COMPARE,
      S_WRITEBACK,
      S_FILL,
      S_FLUSH_SCAN,
      S_FLUSH_WB
   } state_e;

   function automatic int tag_width(input int addr_w, input int index_w);
      return addr_w - index_w;
   endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag and data arrays of the cache: one synchronous-write, registered-read port.
// Left without reset so the arrays map onto block RAM.
module cache_line_store #(
   parameter int INDEX_W = 6,
   parameter int TAG_W   = 7,
   parameter int DATA_W  = 32
) (
   input  logic               clk_i,
   input  logic               we_i,
   input  logic [INDEX_W-1:0] idx_i,
   input  logic [TAG_W-1:0]   tag_i,
   input  logic [DATA_W-1:0]  data_i,
   output logic [TAG_W-1:0]   tag_o,
   output logic [DATA_W-1:0]  data_o
);

   logic [TAG_W+DATA_W-1:0] mem_q [2**INDEX_W];
   logic [TAG_W+DATA_W-1:0] rd_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[idx_i] <= {tag_i, data_i};
      end
      rd_q <= mem_q[idx_i];
   end

   assign tag_o  = rd_q[TAG_W+DATA_W-1:DATA_W];
   assign data_o = rd_q[DATA_W-1:0];

endmodule

// File: rtl/param_data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with one-word lines,
// a request/acknowledge memory port, full flush and saturating hit/miss counters.
module param_data_cache
   import cache_pkg::*;
#(
   parameter int ADDR_W  = 13,
   parameter int DATA_W  = 32,
   parameter int INDEX_W = 6,
   parameter int CNT_W   = 16
) (
   input  logic              clka,
   input  logic              rsta,
   input  logic              ena,
   input  logic              wea,
   input  logic [ADDR_W-1:0] addra,
   input  logic [DATA_W-1:0] dina,
   output logic [DATA_W-1:0] douta,
   output logic              ready,
   output logic              done,
   input  logic              flush,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   localparam int TAG_W = tag_width(ADDR_W, INDEX_W);
   localparam int LINES = 1 << INDEX_W;

   state_e             state_q, state_d;
   logic [LINES-1:0]   valid_q, valid_d, dirty_q, dirty_d;
   logic [INDEX_W-1:0] scan_q, scan_d;
   logic               done_q, done_d;
   logic [DATA_W-1:0]  douta_q, douta_d;
   logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
   logic [CNT_W-1:0]   hit_q, hit_d, miss_q, miss_d;

   logic [ADDR_W-1:0]  addr_q;
   logic               we_q;
   logic [DATA_W-1:0]  din_q;

   logic               ram_we;
   logic [INDEX_W-1:0] ram_idx;
   logic [TAG_W-1:0]   ram_wtag, ram_rtag;
   logic [DATA_W-1:0]  ram_wdata, ram_rdata;

   logic [INDEX_W-1:0] cidx;
   logic [TAG_W-1:0]   ctag;
   logic               accept, ack, hit, store_line;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   assign cidx   = addr_q[INDEX_W-1:0];
   assign ctag   = addr_q[ADDR_W-1:INDEX_W];
   assign ready  = (state_q == S_IDLE) && !rsta;
   assign accept = ready && ena && !flush;
   assign ack    = mem_ack && mem_req_q;
   assign hit    = valid_q[cidx] && (ram_rtag == ctag);

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      scan_d      = scan_q;
      done_d      = 1'b0;
      douta_d     = douta_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      hit_d       = hit_q;
      miss_d      = miss_q;
      ram_we      = 1'b0;
      ram_idx     = cidx;
      ram_wtag    = ctag;
      ram_wdata   = din_q;
      store_line  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // The line is read on the accept edge so COMPARE sees it one cycle later.
            ram_idx = addra[INDEX_W-1:0];
            if (flush) begin
               state_d = S_FLUSH_SCAN;
               scan_d  = '0;
               ram_idx = '0;
            end else if (ena) begin
               state_d = S_COMPARE;
            end
         end
         S_COMPARE: begin
            if (hit) begin
               hit_d = sat_inc(hit_q);
               if (we_q) begin
                  store_line = 1'b1;
               end else begin
                  douta_d = ram_rdata;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               miss_d = sat_inc(miss_q);
               if (valid_q[cidx] && dirty_q[cidx]) begin
                  state_d     = S_WRITEBACK;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = {ram_rtag, cidx};
                  mem_wdata_d = ram_rdata;
               end else if (we_q) begin
                  store_line = 1'b1;
               end else begin
                  state_d    = S_FILL;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = addr_q;
               end
            end
         end
         S_WRITEBACK: begin
            if (ack) begin
               mem_req_d = 1'b0;
               if (we_q) begin
                  store_line = 1'b1;
               end else begin
                  state_d    = S_FILL;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = addr_q;
               end
            end
         end
         S_FILL: begin
            if (ack) begin
               mem_req_d     = 1'b0;
               ram_we        = 1'b1;
               ram_wdata     = mem_rdata;
               valid_d[cidx] = 1'b1;
               dirty_d[cidx] = 1'b0;
               douta_d       = mem_rdata;
               done_d        = 1'b1;
               state_d       = S_IDLE;
            end
         end
         S_FLUSH_SCAN: begin
            if (valid_q[scan_q] && dirty_q[scan_q]) begin
               state_d     = S_FLUSH_WB;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = {ram_rtag, scan_q};
               mem_wdata_d = ram_rdata;
            end else if (&scan_q) begin
               valid_d = '0;
               dirty_d = '0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               scan_d = scan_q + 1'b1;
            end
            // Address the store with the next scan index so its data is ready on arrival.
            ram_idx = scan_d;
         end
         S_FLUSH_WB: begin
            ram_idx = scan_q;
            if (ack) begin
               mem_req_d       = 1'b0;
               dirty_d[scan_q] = 1'b0;
               state_d         = S_FLUSH_SCAN;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (store_line) begin
         ram_we        = 1'b1;
         valid_d[cidx] = 1'b1;
         dirty_d[cidx] = 1'b1;
         done_d        = 1'b1;
         state_d       = S_IDLE;
      end
   end

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         state_q     <= S_IDLE;
         valid_q     <= '0;
         dirty_q     <= '0;
         scan_q      <= '0;
         done_q      <= 1'b0;
         douta_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         hit_q       <= '0;
         miss_q      <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
         scan_q      <= scan_d;
         done_q      <= done_d;
         douta_q     <= douta_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
      end
   end

   always_ff @(posedge clka) begin
      if (accept) begin
         addr_q <= addra;
         we_q   <= wea;
         din_q  <= dina;
      end
   end

   cache_line_store #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W),
      .DATA_W  (DATA_W)
   ) u_store (
      .clk_i  (clka),
      .we_i   (ram_we),
      .idx_i  (ram_idx),
      .tag_i  (ram_wtag),
      .data_i (ram_wdata),
      .tag_o  (ram_rtag),
      .data_o (ram_rdata)
   );

   assign douta      = douta_q;
   assign done       = done_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign hit_count  = hit_q;
   assign miss_count = miss_q;

endmodule

// File: tb/tb_param_data_cache.sv
// Randomised bench for param_data_cache: a line-level cache model plus a
// memory responder with random latency, compared after every request or flush.
module tb_param_data_cache;

   localparam int ADDR_W  = 13;
   localparam int DATA_W  = 32;
   localparam int INDEX_W = 6;
   localparam int CNT_W   = 4;
   localparam int LINES   = 64;
   localparam int CMAX    = 15;

   logic              clka = 1'b0;
   logic              rsta, ena, wea, flush, mem_ack;
   logic [ADDR_W-1:0] addra;
   logic [DATA_W-1:0] dina, mem_rdata;
   logic [DATA_W-1:0] douta, mem_wdata;
   logic              ready, done, mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [CNT_W-1:0]  hit_count, miss_count;

   param_data_cache #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .INDEX_W (INDEX_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clka       (clka),
      .rsta       (rsta),
      .ena        (ena),
      .wea        (wea),
      .addra      (addra),
      .dina       (dina),
      .douta      (douta),
      .ready      (ready),
      .done       (done),
      .flush      (flush),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clka = ~clka;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference model state
   bit          rv     [LINES];
   bit          rdirty [LINES];
   logic [6:0]  rt     [LINES];
   logic [31:0] rdat   [LINES];
   logic [31:0] refmem [8192];
   logic [31:0] mem_arr[8192];
   int          r_hit, r_miss;
   logic [31:0] r_douta;
   logic [45:0] exp_ops[$];
   logic [45:0] log_ops[$];

   bit hold_ack  = 1'b0;
   int spur_req  = 0;

   function automatic int sat(input int c);
      return (c < CMAX) ? c + 1 : CMAX;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < LINES; i++) begin
         rv[i] = 1'b0;
         rdirty[i] = 1'b0;
      end
      r_hit = 0;
      r_miss = 0;
      r_douta = '0;
   endtask

   task automatic predict_req(input bit we, input logic [12:0] a, input logic [31:0] d,
                              output bit is_hit);
      int idx;
      logic [6:0] tag;
      logic [12:0] vaddr;
      idx = int'(a[5:0]);
      tag = a[12:6];
      exp_ops.delete();
      is_hit = rv[idx] && (rt[idx] == tag);
      if (is_hit) begin
         r_hit = sat(r_hit);
         if (we) begin
            rdat[idx] = d;
            rdirty[idx] = 1'b1;
         end else begin
            r_douta = rdat[idx];
         end
      end else begin
         r_miss = sat(r_miss);
         if (rv[idx] && rdirty[idx]) begin
            vaddr = {rt[idx], a[5:0]};
            exp_ops.push_back({1'b1, vaddr, rdat[idx]});
            refmem[vaddr] = rdat[idx];
         end
         rv[idx] = 1'b1;
         rt[idx] = tag;
         if (we) begin
            rdat[idx] = d;
            rdirty[idx] = 1'b1;
         end else begin
            exp_ops.push_back({1'b0, a, 32'h0});
            rdat[idx] = refmem[a];
            rdirty[idx] = 1'b0;
            r_douta = refmem[a];
         end
      end
   endtask

   task automatic predict_flush();
      logic [12:0] vaddr;
      exp_ops.delete();
      for (int i = 0; i < LINES; i++) begin
         if (rv[i] && rdirty[i]) begin
            vaddr = {rt[i], 6'(i)};
            exp_ops.push_back({1'b1, vaddr, rdat[i]});
            refmem[vaddr] = rdat[i];
         end
         rv[i] = 1'b0;
         rdirty[i] = 1'b0;
      end
   endtask

   // Memory responder: random 0..3 cycle wait, one-cycle ack driven off the falling edge.
   initial begin
      bit          busy;
      int          wait_cnt;
      int          spur_done;
      logic [45:0] rec;
      busy = 1'b0;
      wait_cnt = 0;
      spur_done = 0;
      rec = '0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clka);
         if (mem_ack) begin
            mem_ack = 1'b0;
         end else if (rsta) begin
            busy = 1'b0;
         end else if (spur_req != spur_done && !mem_req && !busy) begin
            spur_done = spur_req;
            mem_rdata = 32'hDEAD_BEEF;
            mem_ack = 1'b1;
         end else begin
            if (!busy && mem_req) begin
               busy = 1'b1;
               rec = {mem_we, mem_addr, mem_we ? mem_wdata : 32'h0};
               wait_cnt = $urandom_range(0, 3);
            end
            if (busy && !hold_ack) begin
               if (wait_cnt == 0) begin
                  check("mem_stable", {mem_we, mem_addr, mem_we ? mem_wdata : 32'h0}, rec);
                  if (mem_we) mem_arr[mem_addr] = mem_wdata;
                  else        mem_rdata = mem_arr[mem_addr];
                  log_ops.push_back(rec);
                  mem_ack = 1'b1;
                  busy = 1'b0;
               end else begin
                  wait_cnt--;
               end
            end
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clka);
      while (!ready && n < 100) begin
         @(negedge clka);
         n++;
      end
      if (!ready) check("ready_timeout", 0, 1);
   endtask

   task automatic wait_done(output int cyc);
      bit saw_ready;
      cyc = 0;
      saw_ready = 1'b0;
      do begin
         @(negedge clka);
         cyc++;
         if (!done && ready) saw_ready = 1'b1;
      end while (!done && cyc < 300);
      check("done_seen", done, 1);
      check("ready_busy", saw_ready, 0);
   endtask

   task automatic compare_ops(input string tag);
      check({tag, "_nops"}, log_ops.size(), exp_ops.size());
      for (int i = 0; i < log_ops.size() && i < exp_ops.size(); i++)
         check({tag, "_op"}, log_ops[i], exp_ops[i]);
   endtask

   task automatic check_counts();
      check("douta", douta, r_douta);
      check("hit_count", hit_count, r_hit);
      check("miss_count", miss_count, r_miss);
   endtask

   task automatic run_req(input bit we, input logic [12:0] a, input logic [31:0] d);
      bit h;
      int cyc;
      predict_req(we, a, d, h);
      wait_ready();
      log_ops.delete();
      wea = we;
      addra = a;
      dina = d;
      ena = 1'b1;
      @(posedge clka);
      #1 ena = 1'b0;
      wait_done(cyc);
      if (h) check("hit_latency", cyc, 2);
      compare_ops(we ? "store" : "load");
      check_counts();
   endtask

   task automatic run_flush(input bit with_ena);
      int cyc;
      predict_flush();
      wait_ready();
      log_ops.delete();
      flush = 1'b1;
      ena = with_ena;
      wea = 1'($urandom_range(0, 1));
      addra = 13'($urandom);
      @(posedge clka);
      #1;
      flush = 1'b0;
      ena = 1'b0;
      wait_done(cyc);
      compare_ops("flush");
      check_counts();
   endtask

   function automatic logic [12:0] rand_addr();
      int idx;
      case ($urandom_range(0, 4))
         0: idx = 0;
         1: idx = 5;
         2: idx = 56;
         3: idx = 63;
         default: idx = $urandom_range(0, 63);
      endcase
      return 13'($urandom_range(0, 3) * 64 + idx);
   endfunction

   initial begin
      int n;
      rsta = 1'b1;
      ena = 1'b0;
      wea = 1'b0;
      flush = 1'b0;
      addra = '0;
      dina = '0;
      for (int i = 0; i < 8192; i++) begin
         mem_arr[i] = $urandom;
         refmem[i] = mem_arr[i];
      end
      mem_arr[13'h0238] = 32'd7;
      refmem[13'h0238] = 32'd7;
      model_reset();
      repeat (3) @(negedge clka);
      rsta = 1'b0;
      #1;
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_douta", douta, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_hits", hit_count, 0);
      check("rst_misses", miss_count, 0);

      run_req(1'b0, 13'h0238, '0);
      check("plan_fill_data", douta, 32'd7);
      check("plan_miss1", miss_count, 1);
      run_req(1'b1, 13'h0238, 32'd500);
      run_req(1'b0, 13'h0238, '0);
      check("plan_hit_data", douta, 32'd500);
      run_req(1'b1, 13'h1238, 32'd120);
      run_req(1'b0, 13'h1238, '0);
      check("plan_hit120", douta, 32'd120);
      run_req(1'b0, 13'h0238, '0);
      check("plan_refill", douta, 32'd500);

      run_req(1'b1, 13'h0000, 32'h1111_0000);
      run_req(1'b1, 13'h0045, 32'h2222_0005);
      run_req(1'b1, 13'h003F, 32'h3333_003F);
      run_flush(1'b0);
      check("flush_wb_count", log_ops.size(), 3);
      run_req(1'b0, 13'h0045, '0);
      check("post_flush_data", douta, 32'h2222_0005);

      // Stray acknowledge while idle must not disturb anything.
      wait_ready();
      spur_req++;
      repeat (2) @(negedge clka);
      check("spur_req", mem_req, 0);
      check("spur_done", done, 0);
      check("spur_ready", ready, 1);
      check_counts();

      run_req(1'b1, 13'h0100, 32'hABCD_0001);
      run_flush(1'b1);

      for (int t = 0; t < 400; t++) begin
         if ($urandom_range(0, 24) == 0) run_flush(1'($urandom_range(0, 1)));
         else run_req(1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end

      // Abandon a fill with an asynchronous reset.
      run_flush(1'b0);
      wait_ready();
      hold_ack = 1'b1;
      wea = 1'b0;
      addra = 13'h0238;
      ena = 1'b1;
      @(posedge clka);
      #1 ena = 1'b0;
      n = 0;
      while (!mem_req && n < 20) begin
         @(negedge clka);
         n++;
      end
      check("fill_req_seen", mem_req, 1);
      #2 rsta = 1'b1;
      #1;
      check("async_mem_req", mem_req, 0);
      check("async_done", done, 0);
      @(negedge clka);
      @(negedge clka);
      rsta = 1'b0;
      hold_ack = 1'b0;
      model_reset();
      #1;
      check("rst2_ready", ready, 1);
      check("rst2_hits", hit_count, 0);
      check("rst2_misses", miss_count, 0);
      check("rst2_mem_addr", mem_addr, 0);
      run_req(1'b0, 13'h0238, '0);
      run_req(1'b0, 13'h0238, '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
